multicycle_control: RTL

Multicycle sequencer that turns the single-cycle datapath into a five-step machine (fetch, decode, execute, memory, write-back), so instruction memory, data memory and the ALU can be shared across cycles. The block decodes opcode/funct, drives every datapath enable and mux select per state, and stalls on a handshake with the system-call unit. It also halts the core on an all-zero instruction or an illegal opcode, and keeps cycle and retired-instruction counters for statistics.

---
 rtl/mc_pkg.sv | 39 +++
 rtl/alu_decode.sv | 33 +++
 rtl/multicycle_control.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control sequencer.
// Opcode/funct values follow the MIPS subset the datapath implements.
package mc_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StSyscall,
    StHalt
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSyscall = 6'h0C;
  localparam logic [5:0] FnAdd     = 6'h20;
  localparam logic [5:0] FnSub     = 6'h22;
  localparam logic [5:0] FnAnd     = 6'h24;
  localparam logic [5:0] FnOr      = 6'h25;
  localparam logic [5:0] FnSlt     = 6'h2A;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic [1:0] PcSeq    = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/funct to ALU operation decode.
// valid is low for any opcode or R-type funct the core does not implement.
module alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] aluop,
  output logic       valid
);

  always_comb begin
    aluop = AluAdd;
    valid = 1'b1;
    case (opcode)
      OpRtype: begin
        case (funct)
          FnAdd:   aluop = AluAdd;
          FnSub:   aluop = AluSub;
          FnAnd:   aluop = AluAnd;
          FnOr:    aluop = AluOr;
          FnSlt:   aluop = AluSlt;
          default: valid = 1'b0;
        endcase
      end
      OpLw, OpSw, OpAddi: aluop = AluAdd;
      OpBeq:              aluop = AluSub;
      OpJ:                aluop = AluAdd;
      default:            valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Five-step multicycle sequencer: drives datapath enables per state, stalls on the
// syscall handshake, halts on zero/illegal instructions and keeps statistics counters.
module multicycle_control
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        sys_done,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        reg_dest,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  aluop,
  output logic        sys_req,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_retired
);

  state_e      state_q, state_d;
  logic [5:0]  opcode_q, funct_q;
  logic        illegal_q, illegal_d;
  logic [31:0] cycle_q, retired_q;

  logic [5:0]  dec_opcode, dec_funct;
  logic [2:0]  dec_aluop;
  logic        dec_valid;

  // Decode the live instruction in DECODE, the latched one everywhere else.
  assign dec_opcode = (state_q == StDecode) ? instr[31:26] : opcode_q;
  assign dec_funct  = (state_q == StDecode) ? instr[5:0]   : funct_q;

  alu_decode u_alu_decode (
    .opcode (dec_opcode),
    .funct  (dec_funct),
    .aluop  (dec_aluop),
    .valid  (dec_valid)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        if (instr == 32'd0) begin
          state_d = StHalt;
        end else if (instr[31:26] == OpRtype && instr[5:0] == FnSyscall) begin
          state_d = StSyscall;
        end else if (!dec_valid) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (opcode_q)
          OpLw, OpSw:      state_d = StMem;
          OpRtype, OpAddi: state_d = StWb;
          default:         state_d = StFetch;
        endcase
      end
      StMem:     state_d = (opcode_q == OpLw) ? StWb : StFetch;
      StWb:      state_d = StFetch;
      StSyscall: if (sys_done) state_d = StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      opcode_q  <= 6'd0;
      funct_q   <= 6'd0;
      illegal_q <= 1'b0;
      cycle_q   <= 32'd0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cycle_q   <= cycle_q + 32'd1;
      if (state_q == StDecode) begin
        opcode_q <= instr[31:26];
        funct_q  <= instr[5:0];
      end
      if (state_d == StFetch && state_q != StFetch) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  // Outputs are gated by reset_n so strobes drop without waiting for a clock edge.
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PcSeq;
    reg_write  = 1'b0;
    reg_dest   = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    aluop      = AluAdd;
    sys_req    = 1'b0;
    if (reset_n) begin
      case (state_q)
        StFetch: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
        StExec: begin
          case (opcode_q)
            OpRtype:            aluop   = dec_aluop;
            OpLw, OpSw, OpAddi: alu_src = 1'b1;
            OpBeq: begin
              aluop    = AluSub;
              pc_write = alu_zero;
              pc_src   = PcBranch;
            end
            OpJ: begin
              pc_write = 1'b1;
              pc_src   = PcJump;
            end
            default: ;
          endcase
        end
        StMem: begin
          if (opcode_q == OpLw) mem_read = 1'b1;
          else                  mem_write = 1'b1;
        end
        StWb: begin
          reg_write  = 1'b1;
          reg_dest   = (opcode_q == OpRtype);
          mem_to_reg = (opcode_q == OpLw);
        end
        StSyscall: sys_req = 1'b1;
        default: ;
      endcase
    end
  end

  assign halted        = (state_q == StHalt);
  assign illegal       = illegal_q;
  assign cycle_count   = cycle_q;
  assign instr_retired = retired_q;

endmodule
